// File: rtl/axis_bram_adapter_v2_cntl_if.sv
// Stream-in, stream-out and BRAM port bundle for the AXI-Stream/BRAM adapter controller.
// The master view belongs to the controller; the slave view belongs to the stream ports and BRAM.
interface axis_bram_adapter_v2_cntl_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  s_tvalid;
    logic                  s_tready;
    logic                  s_tlast;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;
    logic                  bram_en;
    logic                  bram_wen;
    logic [ADDR_WIDTH-1:0] bram_index;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [DATA_WIDTH-1:0] bram_dout;

    modport master (
        input  s_tdata, s_tvalid, s_tlast, m_tready, bram_dout,
        output s_tready, m_tdata, m_tvalid, m_tlast,
        output bram_en, bram_wen, bram_index, bram_din
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast, m_tready, bram_dout,
        input  s_tready, m_tdata, m_tvalid, m_tlast,
        input  bram_en, bram_wen, bram_index, bram_din
    );
endinterface

// File: rtl/axis_bram_adapter_v2_cntl.sv
// Moves a contiguous, possibly wrapping, block of words between an AXI-Stream port and a
// single-port BRAM; reads go through a small credit-managed FIFO so backpressure never drops data.
module axis_bram_adapter_v2_cntl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic                  i_rw,
    input  logic [ADDR_WIDTH-1:0] i_index_cntl,
    input  logic [ADDR_WIDTH-1:0] i_size_cntl,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_short_xfer,
    axis_bram_adapter_v2_cntl_if.master io_bus
);
    localparam int DEPTH = RD_LATENCY + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int OW    = $clog2(DEPTH + 1);
    localparam int CW    = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_total;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_popped;
    logic                  r_short;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_index;
    logic [DATA_WIDTH-1:0] r_wr_din;
    logic [RD_LATENCY-1:0] r_inflight;
    logic [DATA_WIDTH-1:0] r_fifo [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [OW-1:0]         r_occ;

    logic [ADDR_WIDTH-1:0] w_span;
    logic [OW-1:0]         w_inflight_cnt;
    logic [OW:0]           w_used;
    logic                  w_beat;
    logic                  w_wr_final;
    logic                  w_issue;
    logic                  w_capture;
    logic                  w_mvalid;
    logic                  w_mlast;
    logic                  w_pop;

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A read may only be issued when a FIFO slot is guaranteed for its data on return.
    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight_cnt = w_inflight_cnt + OW'(r_inflight[i]);
        end
    end

    assign w_span     = i_size_cntl - i_index_cntl;
    assign w_used     = (OW+1)'(r_occ) + (OW+1)'(w_inflight_cnt);
    assign w_beat     = (r_state == WRITE) && io_bus.s_tvalid;
    assign w_wr_final = (r_count + CW'(1)) == r_total;
    assign w_issue    = (r_state == READ) && (w_used < (OW+1)'(DEPTH)) && (r_count < r_total);
    assign w_capture  = r_inflight[RD_LATENCY-1];
    assign w_mvalid   = (r_occ != '0);
    assign w_mlast    = w_mvalid && (r_popped == (r_total - CW'(1)));
    assign w_pop      = w_mvalid && io_bus.m_tready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = i_rw ? WRITE : READ;
            WRITE:   if (w_beat && (w_wr_final || io_bus.s_tlast)) w_next = DONE;
            READ:    if (w_pop && w_mlast) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_addr     <= '0;
            r_total    <= '0;
            r_count    <= '0;
            r_popped   <= '0;
            r_short    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_index <= '0;
            r_wr_din   <= '0;
            r_inflight <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (r_state == IDLE && i_start) begin
                r_addr   <= i_index_cntl;
                r_total  <= CW'(w_span) + CW'(1);
                r_count  <= '0;
                r_popped <= '0;
                r_short  <= 1'b0;
            end
            if (w_beat) begin
                r_wr_en    <= 1'b1;
                r_wr_index <= r_addr;
                r_wr_din   <= io_bus.s_tdata;
                r_addr     <= r_addr + ADDR_WIDTH'(1);
                r_count    <= r_count + CW'(1);
                if (io_bus.s_tlast && !w_wr_final) r_short <= 1'b1;
            end
            if (w_issue) begin
                r_addr  <= r_addr + ADDR_WIDTH'(1);
                r_count <= r_count + CW'(1);
            end
            r_inflight[0] <= w_issue;
            for (int i = 1; i < RD_LATENCY; i++) r_inflight[i] <= r_inflight[i-1];
            if (w_capture) begin
                r_fifo[r_wptr] <= io_bus.bram_dout;
                r_wptr         <= f_next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr   <= f_next_ptr(r_rptr);
                r_popped <= r_popped + CW'(1);
            end
            if (w_capture && !w_pop)      r_occ <= r_occ + OW'(1);
            else if (!w_capture && w_pop) r_occ <= r_occ - OW'(1);
        end
    end

    // The final write of a block lands in the DONE cycle because writes are registered.
    assign o_busy            = (r_state != IDLE);
    assign o_done            = (r_state == DONE);
    assign o_short_xfer      = r_short;
    assign io_bus.s_tready   = (r_state == WRITE);
    assign io_bus.m_tvalid   = w_mvalid;
    assign io_bus.m_tlast    = w_mlast;
    assign io_bus.m_tdata    = w_mvalid ? r_fifo[r_rptr] : '0;
    assign io_bus.bram_en    = w_issue | r_wr_en;
    assign io_bus.bram_wen   = r_wr_en;
    assign io_bus.bram_index = (r_state == READ) ? r_addr : r_wr_index;
    assign io_bus.bram_din   = r_wr_din;
endmodule

// File: tb/tb_axis_bram_adapter_v2_cntl.sv
// Directed bench for the adapter controller: one instance at read latency 1, one at latency 2,
// both fed the same stimulus and each backed by its own behavioural BRAM.
module tb_axis_bram_adapter_v2_cntl;
    localparam int AW = 9;
    localparam int DW = 32;

    typedef struct {
        int              cycle;
        int              addr;
        logic [DW-1:0]   data;
        logic            last;
    } expT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, start, rw, preload;
    logic [AW-1:0] indexCntl, sizeCntl;
    logic [DW-1:0] sTdata;
    logic          sTvalid, sTlast, mTready;
    logic          busyA, doneA, shortA, busyB, doneB, shortB;
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    int            doneCnt [2];
    int            hsCnt [2];
    int            lastHsCyc [2];
    logic          stallPrev [2];
    logic [DW-1:0] heldData [2];
    logic          heldLast [2];
    logic          rdActive;
    expT           wrQ [$];
    expT           rdQA [$];
    expT           rdQB [$];
    expT           wrE;

    axis_bram_adapter_v2_cntl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busA ();
    axis_bram_adapter_v2_cntl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busB ();

    axis_bram_adapter_v2_cntl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dutA (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_rw(rw),
        .i_index_cntl(indexCntl), .i_size_cntl(sizeCntl),
        .o_busy(busyA), .o_done(doneA), .o_short_xfer(shortA), .io_bus(busA)
    );
    axis_bram_adapter_v2_cntl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) dutB (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_rw(rw),
        .i_index_cntl(indexCntl), .i_size_cntl(sizeCntl),
        .o_busy(busyB), .o_done(doneB), .o_short_xfer(shortB), .io_bus(busB)
    );

    assign busA.s_tdata  = sTdata;
    assign busA.s_tvalid = sTvalid;
    assign busA.s_tlast  = sTlast;
    assign busA.m_tready = mTready;
    assign busB.s_tdata  = sTdata;
    assign busB.s_tvalid = sTvalid;
    assign busB.s_tlast  = sTlast;
    assign busB.m_tready = mTready;

    logic [DW-1:0] memA [512];
    logic [DW-1:0] memB [512];
    logic [DW-1:0] q1A, q1B, q2B;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) begin
                memA[i] <= DW'(i);
                memB[i] <= DW'(i);
            end
        end else begin
            if (busA.bram_en && busA.bram_wen) memA[busA.bram_index] <= busA.bram_din;
            if (busB.bram_en && busB.bram_wen) memB[busB.bram_index] <= busB.bram_din;
        end
        if (busA.bram_en) q1A <= memA[busA.bram_index];
        if (busB.bram_en) q1B <= memB[busB.bram_index];
        q2B <= q1B;
        cyc <= cyc + 1;
    end
    assign busA.bram_dout = q1A;
    assign busB.bram_dout = q2B;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rwV, input int idx, input int sz);
        start     = 1'b1;
        rw        = rwV;
        indexCntl = AW'(idx);
        sizeCntl  = AW'(sz);
    endtask

    task automatic rdCheck(input int d, input logic v, input logic r, input logic l,
                           input logic [DW-1:0] dat);
        expT e;
        if (stallPrev[d]) begin
            checkOutput($sformatf("stall_valid[%0d]", d), 64'(v), 64'(1));
            checkOutput($sformatf("stall_data[%0d]", d), 64'(dat), 64'(heldData[d]));
            checkOutput($sformatf("stall_last[%0d]", d), 64'(l), 64'(heldLast[d]));
        end
        if (v && r) begin
            if ((d == 0 ? rdQA.size() : rdQB.size()) == 0) begin
                checkOutput($sformatf("rd_unexpected[%0d]", d), 64'(1), 64'(0));
            end else begin
                e = (d == 0) ? rdQA.pop_front() : rdQB.pop_front();
                checkOutput($sformatf("rd_data[%0d]", d), 64'(dat), 64'(e.data));
                checkOutput($sformatf("rd_last[%0d]", d), 64'(l), 64'(e.last));
                if (e.cycle >= 0) checkOutput($sformatf("rd_cycle[%0d]", d), 64'(cyc), 64'(e.cycle));
            end
            hsCnt[d]++;
            if (l) lastHsCyc[d] = cyc;
        end
        stallPrev[d] = v && !r;
        heldData[d]  = dat;
        heldLast[d]  = l;
    endtask

    // Output-side scoreboard: BRAM writes of instance A plus stream words and done of both.
    always @(negedge clk) begin
        if (rstn && busA.bram_en && busA.bram_wen) begin
            if (wrQ.size() == 0) begin
                checkOutput("wr_unexpected", 64'(1), 64'(0));
            end else begin
                wrE = wrQ.pop_front();
                checkOutput("wr_cycle", 64'(cyc), 64'(wrE.cycle));
                checkOutput("wr_addr", 64'(busA.bram_index), 64'(wrE.addr));
                checkOutput("wr_data", 64'(busA.bram_din), 64'(wrE.data));
            end
        end
        rdCheck(0, busA.m_tvalid, mTready, busA.m_tlast, busA.m_tdata);
        rdCheck(1, busB.m_tvalid, mTready, busB.m_tlast, busB.m_tdata);
        if (doneA) doneCnt[0]++;
        if (doneB) doneCnt[1]++;
        if (rdActive && doneA) checkOutput("rd_done_cycle[0]", 64'(cyc), 64'(lastHsCyc[0] + 1));
        if (rdActive && doneB) checkOutput("rd_done_cycle[1]", 64'(cyc), 64'(lastHsCyc[1] + 1));
    end

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_busy"}, 64'(busyA), 64'(0));
        checkOutput({pfx, "_done"}, 64'(doneA), 64'(0));
        checkOutput({pfx, "_short"}, 64'(shortA), 64'(0));
        checkOutput({pfx, "_s_tready"}, 64'(busA.s_tready), 64'(0));
        checkOutput({pfx, "_m_tvalid"}, 64'(busA.m_tvalid), 64'(0));
        checkOutput({pfx, "_m_tlast"}, 64'(busA.m_tlast), 64'(0));
        checkOutput({pfx, "_bram_en"}, 64'(busA.bram_en), 64'(0));
        checkOutput({pfx, "_bram_wen"}, 64'(busA.bram_wen), 64'(0));
        checkOutput({pfx, "_bram_index"}, 64'(busA.bram_index), 64'(0));
        checkOutput({pfx, "_bram_din"}, 64'(busA.bram_din), 64'(0));
        checkOutput({pfx, "_m_tdata"}, 64'(busA.m_tdata), 64'(0));
        checkOutput({pfx, "_instB"}, 64'({busyB, doneB, shortB, busB.m_tvalid, busB.bram_en, busB.m_tdata}), 64'(0));
    endtask

    task automatic runWrite(input int idx, input int sz, input int beats, input int lastAt,
                            input logic expShort, input logic busyTest);
        expT e;
        int  k = 0;
        applyStimulus(1'b1, idx, sz);
        sTvalid = 1'b0;
        tick();
        start = 1'b0;
        checkOutput("wr_short_cleared", 64'(shortA), 64'(0));
        while (k < beats) begin
            if (busyTest && $urandom_range(0, 2) == 0) begin
                sTvalid = 1'b0;
                sTlast  = 1'b0;
                tick();
                continue;
            end
            if (busyTest && k == 1) applyStimulus(1'b0, 30, 40);
            sTvalid = 1'b1;
            sTdata  = $urandom;
            sTlast  = (k == lastAt);
            e = '{cycle: cyc + 1, addr: (idx + k) % 512, data: sTdata, last: 1'b0};
            wrQ.push_back(e);
            checkOutput("wr_tready", 64'(busA.s_tready), 64'(1));
            tick();
            start = 1'b0;
            k++;
        end
        sTvalid = 1'b0;
        sTlast  = 1'b0;
        checkOutput("wr_done", 64'({doneA, doneB}), 64'(2'b11));
        checkOutput("wr_busy_at_done", 64'(busyA), 64'(1));
        checkOutput("wr_tready_drop", 64'(busA.s_tready), 64'(0));
        checkOutput("wr_short", 64'({shortA, shortB}), 64'({expShort, expShort}));
        tick();
        checkOutput("wr_idle", 64'({busyA, doneA}), 64'(0));
        tick();
        checkOutput("wr_all_written", 64'(wrQ.size()), 64'(0));
    endtask

    task automatic runRead(input int idx, input int sz, input logic randomReady);
        expT e;
        int  n = ((sz - idx) & 511) + 1;
        int  base;
        int  guard = 0;
        int  d0 = doneCnt[0];
        int  d1 = doneCnt[1];
        rdActive = 1'b1;
        mTready  = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        applyStimulus(1'b0, idx, sz);
        base = cyc;
        for (int k = 0; k < n; k++) begin
            e = '{cycle: randomReady ? -1 : base + 3 + k, addr: 0, data: DW'((idx + k) % 512), last: (k == n - 1)};
            rdQA.push_back(e);
            e.cycle = randomReady ? -1 : base + 4 + k;
            rdQB.push_back(e);
        end
        tick();
        start = 1'b0;
        checkOutput("rd_first_en", 64'({busA.bram_en, busA.bram_wen, busyA}), 64'(3'b101));
        if (randomReady) mTready = 1'($urandom_range(0, 1));
        tick();
        checkOutput("rd_no_early_valid", 64'(busA.m_tvalid), 64'(0));
        while ((doneCnt[0] == d0 || doneCnt[1] == d1) && guard < 400) begin
            if (randomReady) mTready = 1'($urandom_range(0, 1));
            checkOutput("rd_no_write", 64'({busA.bram_wen, busB.bram_wen}), 64'(0));
            tick();
            guard++;
        end
        if (guard >= 400) checkOutput("rd_timeout", 64'(0), 64'(1));
        mTready = 1'b1;
        repeat (2) tick();
        checkOutput("rd_done_once[0]", 64'(doneCnt[0] - d0), 64'(1));
        checkOutput("rd_done_once[1]", 64'(doneCnt[1] - d1), 64'(1));
        checkOutput("rd_drained", 64'(rdQA.size() + rdQB.size()), 64'(0));
        checkOutput("rd_idle", 64'({busyA, busyB, busA.bram_en, busB.bram_en}), 64'(0));
        rdActive = 1'b0;
    endtask

    initial begin
        int guard;
        int h0;
        int dA;
        int dB;
        rstn = 1'b0; start = 1'b0; rw = 1'b0; preload = 1'b0;
        indexCntl = '0; sizeCntl = '0;
        sTdata = '0; sTvalid = 1'b0; sTlast = 1'b0; mTready = 1'b1;
        rdActive = 1'b0;
        for (int i = 0; i < 2; i++) begin
            doneCnt[i] = 0; hsCnt[i] = 0; lastHsCyc[i] = 0;
            stallPrev[i] = 1'b0; heldData[i] = '0; heldLast[i] = 1'b0;
        end
        repeat (2) tick();
        checkResetOutputs("reset");
        rstn = 1'b1;
        tick();

        $display("[TB] write 0..15, tlast on the final beat");
        runWrite(0, 15, 16, 15, 1'b0, 1'b0);
        $display("[TB] wrapping write 510..2");
        runWrite(510, 2, 5, -1, 1'b0, 1'b0);
        $display("[TB] wrapping write cut short by tlast on beat 3");
        runWrite(510, 2, 3, 2, 1'b1, 1'b0);
        $display("[TB] write 20..23 with valid gaps and a start pulse while busy");
        runWrite(20, 23, 4, -1, 1'b0, 1'b1);

        preload = 1'b1;
        tick();
        preload = 1'b0;
        $display("[TB] read 4..11 at full throughput");
        runRead(4, 11, 1'b0);
        $display("[TB] read 0..31 with random backpressure");
        runRead(0, 31, 1'b1);
        $display("[TB] wrapping read 510..1 with random backpressure");
        runRead(510, 1, 1'b1);

        $display("[TB] reset in the middle of a read");
        rdActive = 1'b1;
        applyStimulus(1'b0, 0, 31);
        for (int k = 0; k < 32; k++) begin
            rdQA.push_back('{cycle: -1, addr: 0, data: DW'(k), last: (k == 31)});
            rdQB.push_back('{cycle: -1, addr: 0, data: DW'(k), last: (k == 31)});
        end
        h0 = hsCnt[0];
        tick();
        start = 1'b0;
        guard = 0;
        while (hsCnt[0] - h0 < 5 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) checkOutput("rst_wait_timeout", 64'(0), 64'(1));
        dA = doneCnt[0];
        dB = doneCnt[1];
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        rdQA.delete();
        rdQB.delete();
        rdActive = 1'b0;
        checkResetOutputs("midreset");
        repeat (3) tick();
        checkOutput("midreset_no_done", 64'({doneCnt[0] - dA, doneCnt[1] - dB}), 64'(0));

        $display("[TB] single-word read 0..0");
        runRead(0, 0, 1'b0);

        checkOutput("final_queues_empty", 64'(wrQ.size() + rdQA.size() + rdQB.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=completion");
        $fatal(1, "[TB] simulation did not complete");
    end
endmodule

// File: doc/axis_bram_adapter_v2_cntl.md
# axis_bram_adapter_v2_cntl

Parametrised successor of the AXI-Stream/BRAM adapter controller. Moves a contiguous, optionally wrapping, block of words between an AXI-Stream port and a single-port BRAM in either direction:

- write mode: stream → BRAM;
- read mode: BRAM → stream, with full-throughput backpressure handling.

Read latency, data width and address width are parameters. It sits between the adapter's AXI-Stream slave/master ports and the BRAM primitive, and is programmed per transfer by the register block.

## Interface
- `ADDR_WIDTH`, 9, BRAM address width.
- `DATA_WIDTH`, 32, stream and BRAM word width.
- `RD_LATENCY`, 1, BRAM read latency in cycles (1 or 2).

Ports:
- `clk` in 1: the single clock; all logic on rising edge.
- `rstn` in 1: synchronous active-low reset.
- `start` in 1: one-cycle pulse launching a transfer; sampled only in IDLE.
- `rw` in 1: direction; 1 = write (stream→BRAM), 0 = read (BRAM→stream); latched on start.
- `index_cntl` in ADDR_WIDTH: first address; latched on start.
- `size_cntl` in ADDR_WIDTH: last address, inclusive; latched on start.
- `busy` out 1: high from the cycle after an accepted start until the cycle after done.
- `done` out 1: one-cycle completion pulse.
- `short_xfer` out 1: sticky until the next start; set when s_tlast ends a write early.
- `s_tdata` in DATA_WIDTH; `s_tvalid` in 1; `s_tready` out 1; `s_tlast` in 1: stream in.
- `m_tdata` out DATA_WIDTH; `m_tvalid` out 1; `m_tready` in 1; `m_tlast` out 1: stream out.
- `bram_en` out 1; `bram_wen` out 1; `bram_index` out ADDR_WIDTH; `bram_din` out DATA_WIDTH; `bram_dout` in DATA_WIDTH.

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE → WRITE on start&rw. IDLE → READ on start&!rw. Start outside IDLE is ignored.
- Word count N = ((size_cntl − index_cntl) mod 2^ADDR_WIDTH) + 1.
  - Addresses increment modulo 2^ADDR_WIDTH, so end < start wraps through 0.
  - size_cntl == index_cntl gives N = 1.
- WRITE:
  - s_tready = 1 throughout WRITE.
  - Each s_tvalid&s_tready beat produces one registered BRAM write at the next address.
  - After N beats → DONE. Any further s_tlast is ignored.
  - s_tlast on beat k < N: that beat is written, short_xfer is set, and the block goes → DONE.
- READ:
  - Internal output FIFO of depth D = RD_LATENCY + 2.
  - A read is issued (bram_en=1, bram_wen=0) only if FIFO occupancy plus in-flight reads < D, and issued reads < N.
  - bram_dout is captured into the FIFO RD_LATENCY cycles after issue.
  - The FIFO head drives m_tdata/m_tvalid.
  - m_tlast = 1 exactly on the N-th word.
  - The m_tlast handshake → DONE.
- DONE: lasts one cycle with done=1, then → IDLE.
- Reset (also mid-transfer): state IDLE, FIFO and in-flight counts cleared, all outputs 0. An interrupted transfer produces no done.

## Timing
- Reset values: busy, done, short_xfer, s_tready, m_tvalid, m_tlast, bram_en, bram_wen = 0; bram_index, bram_din, m_tdata = 0.
- Start is sampled at cycle 0; busy=1 and the WRITE/READ state begin at cycle 1.
- Write:
  - A beat accepted at cycle n gives bram_en=bram_wen=1 with bram_index/bram_din at cycle n+1.
  - The final beat at cycle n gives done at cycle n+1, IDLE at n+2.
  - s_tready drops in the cycle after the final beat.
- Read:
  - First bram_en at cycle 1; first m_tvalid at cycle 2+RD_LATENCY.
  - With m_tready held 1: one word per cycle, no bubbles.
  - m_tlast handshake at cycle n gives done at n+1.
- Backpressure: m_tdata/m_tlast hold stable while m_tvalid&!m_tready; no word is lost or duplicated (FIFO never overflows by credit rule).
- bram_en is never 1 outside WRITE/READ. bram_wen is never 1 in READ.

## Test plan
- Write 0..15, s_tvalid=1 continuously, data = 0x100+i → writes at addresses 0..15 on cycles 2..17, s_tready falls at cycle 17, done at cycle 17, short_xfer=0.
- Write start=510, end=2, ADDR_WIDTH=9 → 5 writes at 510, 511, 0, 1, 2; done after the 5th write; s_tlast on the 3rd beat in a rerun → 3 writes, short_xfer=1.
- Read 4..11 from BRAM model preloaded mem[i]=i, RD_LATENCY=1, m_tready=1 → m_tvalid from cycle 3, m_tdata 4..11 on consecutive cycles, m_tlast only with 11, done the cycle after.
- Read 0..31, RD_LATENCY=2, m_tready random (50%) → exact sequence 0..31, data stable while stalled, FIFO occupancy never exceeds 4, one m_tlast.
- rstn=0 for one cycle mid-read after 5 words → all outputs 0 next cycle, no done; new start read 0..0 → single word with m_tlast, done.
- start pulsed while busy → ignored; latched size unchanged; transfer completes with the original N.
